pong_draw_control: RTL and testbench

- Control FSM for the Pong drawing datapath. It sequences load, draw, wait, erase and move for the ball and both paddles.
- Drives the datapath selects and enables. Consumes the datapath status flags fin_DE and fin_Wait.
- Drives the VGA adapter write-enable (plot).
- Adds a per-shape watchdog and a frame counter for debug.

---
 rtl/pong_pkg.sv | 30 +++
 rtl/pong_draw_control_watchdog.sv | 26 ++
 rtl/pong_draw_control.sv | 113 +++++++++++
 tb/tb_pong_draw_control.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared states, select codes and helpers for the Pong draw controller.
package pong_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_DRAW_B,
        S_DRAW_P1,
        S_DRAW_P2,
        S_WAIT,
        S_ERASE_B,
        S_ERASE_P1,
        S_ERASE_P2,
        S_MOVE
    } state_t;

    localparam logic [1:0] SEL_BALL = 2'd0;
    localparam logic [1:0] SEL_P1   = 2'd1;
    localparam logic [1:0] SEL_P2   = 2'd2;
    localparam logic [1:0] SEL_NONE = 2'd3;

    localparam logic COL_DRAW  = 1'b0;
    localparam logic COL_ERASE = 1'b1;

    function automatic logic is_shape(input state_t s);
        return (s == S_DRAW_B)  || (s == S_DRAW_P1)  || (s == S_DRAW_P2) ||
               (s == S_ERASE_B) || (s == S_ERASE_P1) || (s == S_ERASE_P2);
    endfunction

endpackage

// File: rtl/pong_draw_control_watchdog.sv
// Per-shape cycle budget: expires on the last allowed cycle of a state.
module pong_watchdog #(
    parameter int WATCHDOG_CYCLES = 1024
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(WATCHDOG_CYCLES - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clock) begin
        if (!resetn || clear)
            r_count <= '0;
        else if (enable)
            r_count <= r_count + CW'(1);
    end

    assign expire = enable && (r_count == LAST);

endmodule

// File: rtl/pong_draw_control.sv
// Sequencer for load/draw/wait/erase/move of the ball and both paddles.
module pong_draw_control
    import pong_pkg::*;
#(
    parameter int WATCHDOG_CYCLES = 1024,
    parameter int FRAME_W         = 16
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               go,
    input  logic               pause,
    input  logic               fin_DE,
    input  logic               fin_Wait,
    output logic [1:0]         sel_out,
    output logic               sel_col,
    output logic               ld_val,
    output logic               en_delayCounter,
    output logic               en_shape,
    output logic               plot,
    output logic               move,
    output logic [FRAME_W-1:0] frame_count,
    output logic               busy,
    output logic               timeout_err
);

    state_t             r_state;
    state_t             w_next;
    logic               w_shape;
    logic               w_expire;
    logic               w_adv;
    logic               w_wd_clr;
    logic [FRAME_W-1:0] r_frame;
    logic               r_timeout;

    assign w_shape  = is_shape(r_state);
    assign w_adv    = fin_DE || w_expire;
    assign w_wd_clr = (w_next != r_state) || !w_shape;

    pong_watchdog #(
        .WATCHDOG_CYCLES(WATCHDOG_CYCLES)
    ) u_wd (
        .clock (clock),
        .resetn(resetn),
        .clear (w_wd_clr),
        .enable(w_shape),
        .expire(w_expire)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:     if (go) w_next = S_LOAD;
            S_LOAD:     w_next = S_DRAW_B;
            S_DRAW_B:   if (w_adv) w_next = S_DRAW_P1;
            S_DRAW_P1:  if (w_adv) w_next = S_DRAW_P2;
            S_DRAW_P2:  if (w_adv) w_next = S_WAIT;
            // pause wins over a simultaneous fin_Wait
            S_WAIT:     if (fin_Wait && !pause) w_next = S_ERASE_B;
            S_ERASE_B:  if (w_adv) w_next = S_ERASE_P1;
            S_ERASE_P1: if (w_adv) w_next = S_ERASE_P2;
            S_ERASE_P2: if (w_adv) w_next = S_MOVE;
            S_MOVE:     w_next = S_DRAW_B;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_frame   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_MOVE)
                r_frame <= r_frame + FRAME_W'(1);
            if (w_expire && !fin_DE)
                r_timeout <= 1'b1;
        end
    end

    always_comb begin
        sel_out         = SEL_NONE;
        sel_col         = COL_DRAW;
        ld_val          = 1'b0;
        en_delayCounter = 1'b0;
        en_shape        = 1'b0;
        plot            = 1'b0;
        move            = 1'b0;
        unique case (r_state)
            S_LOAD:     ld_val = 1'b1;
            S_DRAW_B:   begin sel_out = SEL_BALL; plot = 1'b1; en_shape = 1'b1; end
            S_DRAW_P1:  begin sel_out = SEL_P1;   plot = 1'b1; en_shape = 1'b1; end
            S_DRAW_P2:  begin sel_out = SEL_P2;   plot = 1'b1; en_shape = 1'b1; end
            S_WAIT:     en_delayCounter = !pause;
            S_ERASE_B:  begin
                sel_out = SEL_BALL; sel_col = COL_ERASE; plot = 1'b1; en_shape = 1'b1;
            end
            S_ERASE_P1: begin
                sel_out = SEL_P1; sel_col = COL_ERASE; plot = 1'b1; en_shape = 1'b1;
            end
            S_ERASE_P2: begin
                sel_out = SEL_P2; sel_col = COL_ERASE; plot = 1'b1; en_shape = 1'b1;
            end
            S_MOVE:     move = 1'b1;
            default:    ;
        endcase
    end

    assign frame_count = r_frame;
    assign busy        = (r_state != S_IDLE);
    assign timeout_err = r_timeout;

endmodule

// File: tb/tb_pong_draw_control.sv
// Directed bench: nominal datapath model on one instance, watchdog/wrap on a second.
module tb_pong_draw_control;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int pass_cnt = 0;
    int total    = 0;

    // instance A: default parameters with a datapath/delay model
    logic        a_resetn = 1'b0, a_go = 1'b0, a_pause = 1'b0;
    logic        a_fin_DE, a_fin_Wait;
    logic [1:0]  a_sel_out;
    logic        a_sel_col, a_ld_val, a_en_dly, a_en_shape, a_plot, a_move;
    logic [15:0] a_frame;
    logic        a_busy, a_tmo;
    int          a_shape_cnt = 0;
    int          a_dcnt = 0;

    pong_draw_control dut_a (
        .clock(clock), .resetn(a_resetn), .go(a_go), .pause(a_pause),
        .fin_DE(a_fin_DE), .fin_Wait(a_fin_Wait),
        .sel_out(a_sel_out), .sel_col(a_sel_col), .ld_val(a_ld_val),
        .en_delayCounter(a_en_dly), .en_shape(a_en_shape), .plot(a_plot),
        .move(a_move), .frame_count(a_frame), .busy(a_busy),
        .timeout_err(a_tmo)
    );

    assign a_fin_DE   = a_plot && (a_shape_cnt == ((a_sel_out == 2'd0) ? 15 : 63));
    assign a_fin_Wait = (a_dcnt == 0);

    always @(posedge clock) begin
        if (!a_resetn)
            a_shape_cnt <= 0;
        else if (a_en_shape)
            a_shape_cnt <= a_fin_DE ? 0 : a_shape_cnt + 1;
        if (!a_resetn || !a_en_dly)
            a_dcnt <= 99;
        else if (a_dcnt != 0)
            a_dcnt <= a_dcnt - 1;
    end

    // instance B: 8-cycle watchdog, 2-bit frame counter
    logic        b_resetn = 1'b0, b_go = 1'b0, b_pause = 1'b0;
    logic        b_fin_DE = 1'b0, b_fin_Wait = 1'b1;
    logic [1:0]  b_sel_out;
    logic        b_sel_col, b_ld_val, b_en_dly, b_en_shape, b_plot, b_move;
    logic [1:0]  b_frame;
    logic        b_busy, b_tmo;

    pong_draw_control #(.WATCHDOG_CYCLES(8), .FRAME_W(2)) dut_b (
        .clock(clock), .resetn(b_resetn), .go(b_go), .pause(b_pause),
        .fin_DE(b_fin_DE), .fin_Wait(b_fin_Wait),
        .sel_out(b_sel_out), .sel_col(b_sel_col), .ld_val(b_ld_val),
        .en_delayCounter(b_en_dly), .en_shape(b_en_shape), .plot(b_plot),
        .move(b_move), .frame_count(b_frame), .busy(b_busy),
        .timeout_err(b_tmo)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        a_resetn = 1'b0;
        b_resetn = 1'b0;
        tick();
        tick();
        a_resetn = 1'b1;
        b_resetn = 1'b1;
        total++;
        if ({a_busy, a_plot, a_sel_out, a_ld_val, a_move, a_en_dly, a_en_shape} !== 8'b00110000)
            $display("FAIL reset_outs: got %b want 00110000",
                     {a_busy, a_plot, a_sel_out, a_ld_val, a_move, a_en_dly, a_en_shape});
        else pass_cnt++;
        total++;
        if (a_frame !== 16'd0 || a_tmo !== 1'b0)
            $display("FAIL reset_regs: got frame=%0d tmo=%b want 0/0", a_frame, a_tmo);
        else pass_cnt++;
    endtask

    task automatic test_load();
        a_go = 1'b1;
        tick();
        a_go = 1'b0;
        total++;
        if (a_ld_val !== 1'b1 || a_sel_out !== 2'd3 || a_busy !== 1'b1)
            $display("FAIL load: got ld=%b sel=%0d busy=%b want 1/3/1", a_ld_val, a_sel_out, a_busy);
        else pass_cnt++;
        tick();
        total++;
        if ({a_ld_val, a_sel_out, a_sel_col, a_plot, a_en_shape} !== 6'b000011)
            $display("FAIL draw_b_entry: got %b want 000011",
                     {a_ld_val, a_sel_out, a_sel_col, a_plot, a_en_shape});
        else pass_cnt++;
    endtask

    task automatic test_draw();
        int plots;
        logic [7:0] seq;
        logic [1:0] last;
        plots = 0;
        seq   = 8'h00;
        last  = 2'd0;
        for (int i = 0; i < 1000; i++) begin
            if (!a_plot) break;
            plots++;
            if (a_sel_out != last) begin
                seq  = {seq[5:0], a_sel_out};
                last = a_sel_out;
            end
            tick();
        end
        total++;
        if (plots !== 144) $display("FAIL draw_plots: got %0d want 144", plots);
        else pass_cnt++;
        total++;
        if (seq !== 8'h06) $display("FAIL draw_order: got %h want 06", seq);
        else pass_cnt++;
        total++;
        if (a_sel_out !== 2'd3 || a_en_dly !== 1'b1)
            $display("FAIL wait_entry: got sel=%0d en=%b want 3/1", a_sel_out, a_en_dly);
        else pass_cnt++;
    endtask

    task automatic test_wait_erase_move();
        int n;
        int plots;
        n = 0;
        while (!a_plot && n < 1000) begin n++; tick(); end
        total++;
        if (n !== 100) $display("FAIL wait_len: got %0d want 100", n);
        else pass_cnt++;
        total++;
        if (a_sel_col !== 1'b1 || a_sel_out !== 2'd0)
            $display("FAIL erase_b: got col=%b sel=%0d want 1/0", a_sel_col, a_sel_out);
        else pass_cnt++;
        plots = 0;
        n = 0;
        while (!a_move && n < 1000) begin
            if (a_plot) plots++;
            n++;
            tick();
        end
        total++;
        if (plots !== 144 || a_frame !== 16'd0)
            $display("FAIL erase_plots: got %0d frame=%0d want 144/0", plots, a_frame);
        else pass_cnt++;
        tick();
        total++;
        if (a_move !== 1'b0 || a_frame !== 16'd1)
            $display("FAIL move_pulse: got move=%b frame=%0d want 0/1", a_move, a_frame);
        else pass_cnt++;
        total++;
        if ({a_sel_out, a_sel_col, a_plot} !== 4'b0001)
            $display("FAIL redraw: got %b want 0001", {a_sel_out, a_sel_col, a_plot});
        else pass_cnt++;
    endtask

    task automatic test_pause();
        int n;
        n = 0;
        while (a_sel_out != 2'd3 && n < 1000) begin n++; tick(); end
        repeat (99) tick();
        a_pause = 1'b1;
        #1;
        total++;
        if (a_en_dly !== 1'b0 || a_fin_Wait !== 1'b1)
            $display("FAIL pause_collide: got en=%b finw=%b want 0/1", a_en_dly, a_fin_Wait);
        else pass_cnt++;
        repeat (6) tick();
        total++;
        if (a_sel_out !== 2'd3 || a_plot !== 1'b0 || a_en_dly !== 1'b0)
            $display("FAIL pause_hold: got sel=%0d plot=%b en=%b want 3/0/0",
                     a_sel_out, a_plot, a_en_dly);
        else pass_cnt++;
        a_pause = 1'b0;
        #1;
        n = 0;
        while (!a_plot && n < 1000) begin n++; tick(); end
        total++;
        if (n !== 100 || a_sel_col !== 1'b1)
            $display("FAIL pause_release: got %0d col=%b want 100/1", n, a_sel_col);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        while (a_sel_out != 2'd1 && n < 1000) begin n++; tick(); end
        repeat (3) tick();
        a_resetn = 1'b0;
        tick();
        total++;
        if (a_busy !== 1'b0 || a_plot !== 1'b0 || a_frame !== 16'd0 || a_sel_out !== 2'd3)
            $display("FAIL reset_mid: got busy=%b plot=%b frame=%0d sel=%0d want 0/0/0/3",
                     a_busy, a_plot, a_frame, a_sel_out);
        else pass_cnt++;
        a_resetn = 1'b1;
        tick();
    endtask

    task automatic test_watchdog();
        int n;
        total++;
        if (b_tmo !== 1'b0) $display("FAIL wd_reset: got %b want 0", b_tmo);
        else pass_cnt++;
        b_go = 1'b1;
        tick();
        b_go = 1'b0;
        tick();
        for (int s = 0; s < 3; s++) begin
            n = 0;
            while (b_plot && b_sel_out == 2'(s) && n < 100) begin n++; tick(); end
            total++;
            if (n !== 8) $display("FAIL wd_len%0d: got %0d want 8", s, n);
            else pass_cnt++;
        end
        total++;
        if (b_tmo !== 1'b1) $display("FAIL wd_flag: got %b want 1", b_tmo);
        else pass_cnt++;
    endtask

    task automatic test_frame_wrap();
        int n;
        for (int f = 1; f <= 4; f++) begin
            n = 0;
            while (!b_move && n < 200) begin n++; tick(); end
            tick();
            total++;
            if (b_frame !== 2'(f % 4))
                $display("FAIL frame_wrap%0d: got %0d want %0d", f, b_frame, f % 4);
            else pass_cnt++;
        end
        total++;
        if (b_tmo !== 1'b1) $display("FAIL wd_sticky: got %b want 1", b_tmo);
        else pass_cnt++;
        b_resetn = 1'b0;
        tick();
        b_resetn = 1'b1;
        total++;
        if (b_tmo !== 1'b0 || b_frame !== 2'd0)
            $display("FAIL wd_clear: got tmo=%b frame=%0d want 0/0", b_tmo, b_frame);
        else pass_cnt++;
    endtask

    task automatic test_wd_boundary();
        b_go = 1'b1;
        tick();
        b_go = 1'b0;
        tick();
        repeat (7) tick();
        b_fin_DE = 1'b1;
        tick();
        b_fin_DE = 1'b0;
        total++;
        if (b_sel_out !== 2'd1 || b_tmo !== 1'b0)
            $display("FAIL wd_edge: got sel=%0d tmo=%b want 1/0", b_sel_out, b_tmo);
        else pass_cnt++;
    endtask

    initial begin
        #1;
        test_reset();
        test_load();
        test_draw();
        test_wait_erase_move();
        test_pause();
        test_reset_mid();
        test_watchdog();
        test_frame_wrap();
        test_wd_boundary();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
